// File: rtl/sdf_stage_ctrl.sv
// rtl/sdf_stage_ctrl.sv - sequencing controller for one SDF butterfly stage
module sdf_stage_ctrl #(
  parameter int DELAY = 1,
  parameter int CW    = $clog2(DELAY) + 1
) (
  input  logic clk,
  input  logic clear,
  input  logic in_valid,
  input  logic in_sof,
  output logic in_ready,
  output logic sel,
  output logic sel_1,
  output logic out_valid,
  output logic out_sof,
  output logic out_eof,
  output logic frame_err,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BFLY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(DELAY - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          err_q, err_d;

  // State, phase counter, pending-lower flag and registered error pulse
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. LOAD with pend set and cnt at zero is the cycle right
  // after the last butterfly: it already emits the first lower result and
  // decides between a back-to-back frame (in_sof) and a plain drain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            state_d = (DELAY == 1) ? BFLY : LOAD;
            cnt_d   = (DELAY == 1) ? '0 : ONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (pend_q && (cnt_q == '0)) begin
          if (in_valid && in_sof) begin
            state_d = (DELAY == 1) ? BFLY : LOAD;
            cnt_d   = (DELAY == 1) ? '0 : ONE;
            pend_d  = (DELAY == 1) ? 1'b0 : 1'b1;
          end else begin
            err_d   = in_valid;
            state_d = (DELAY == 1) ? IDLE : DRAIN;
            cnt_d   = (DELAY == 1) ? '0 : ONE;
            pend_d  = (DELAY == 1) ? 1'b0 : 1'b1;
          end
        end else if (!in_valid) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (in_sof) begin
          err_d   = 1'b1;
          state_d = (DELAY == 1) ? BFLY : LOAD;
          cnt_d   = (DELAY == 1) ? '0 : ONE;
          pend_d  = 1'b0;
        end else if (cnt_q == LAST) begin
          state_d = BFLY;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      BFLY: begin
        if (!in_valid) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (in_sof) begin
          err_d   = 1'b1;
          state_d = (DELAY == 1) ? BFLY : LOAD;
          cnt_d   = (DELAY == 1) ? '0 : ONE;
          pend_d  = 1'b0;
        end else if (cnt_q == LAST) begin
          state_d = LOAD;
          cnt_d   = '0;
          pend_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // Output decode from registers only; no input reaches an output directly
  always_comb begin
    sel       = 1'b0;
    sel_1     = 1'b0;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    case (state_q)
      LOAD: begin
        sel_1     = pend_q;
        out_valid = pend_q;
        out_eof   = pend_q && (cnt_q == LAST);
      end
      BFLY: begin
        sel       = 1'b1;
        out_valid = 1'b1;
        out_sof   = (cnt_q == '0);
      end
      DRAIN: begin
        sel_1     = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b1;
        out_eof   = (cnt_q == LAST);
      end
      default: begin
        sel = 1'b0;
      end
    endcase
  end

  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule
